// File: rtl/aes_core_arbiter.sv
// Two-requester round-robin front end for a single shared AES core.
// Grants one block at a time, waits for core_done or a timeout, then returns one result pulse.
module aes_core_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [127:0] req_data0,
  input  logic [127:0] req_data1,
  output logic [1:0]   ack,
  output logic         core_start,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic         core_done,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        last;
  logic        grant;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ~last;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      last         <= 1'b1;
      ack          <= '0;
      core_start   <= 1'b0;
      core_data_in <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      ack       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            core_data_in <= grant ? req_data1 : req_data0;
            rsp_id       <= grant;
            ack          <= grant ? 2'b10 : 2'b01;
            core_start   <= 1'b1;
            tmo_cnt      <= '0;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // core_done takes priority over a timeout landing on the same edge
          if (core_done) begin
            rsp_data   <= core_data_out;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            core_start <= 1'b0;
            state      <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            core_start <= 1'b0;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          last  <= rsp_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
